alu_sub_issue: RTL and testbench

Upstream issue stage for the ALU subtracter. Accepts operand pairs on a valid/ready interface and buffers them in a small FIFO. Issues each pair to the subtracter with a one-cycle enable pulse, captures the registered difference and returns it downstream with status flags on a second valid/ready interface. Lets the register-read stage stall-free hand off subtract operations while the subtracter runs at its own pace.

---
 rtl/alu_sub_issue_pkg.sv | 34 +++
 rtl/alu_sub_issue_if.sv | 39 +++
 rtl/sub_operand_fifo.sv | 46 ++++
 rtl/alu_sub_issue.sv | 130 +++++++++++++
 tb/tb_alu_sub_issue.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sub_issue_pkg.sv
// Shared definitions for the ALU subtracter issue stage: data width,
// FSM state encodings and the status-flag helper.
`ifndef ALU_SUB_ISSUE_DEFS
`define ALU_SUB_ISSUE_DEFS
`define DATA_WIDTH 16
`endif

package alu_sub_issue_pkg;

    localparam int unsigned DATA_WIDTH = `DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic zero;
        logic negative;
        logic overflow;
    } sub_flags_t;

    // Overflow on a - b: operand signs differ and the result sign differs from a.
    function automatic sub_flags_t sub_flags(input logic is_zero, input logic res_msb,
                                             input logic sign1, input logic sign2);
        sub_flags_t f;
        f.zero     = is_zero;
        f.negative = res_msb;
        f.overflow = (sign1 != sign2) && (res_msb != sign1);
        return f;
    endfunction

endpackage

// File: rtl/alu_sub_issue_if.sv
// Bundle of the operand input, subtracter and result output handshakes.
interface alu_sub_issue_if
    import alu_sub_issue_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_op1;
    logic [WIDTH-1:0] in_op2;

    logic             sub_enable;
    logic [WIDTH-1:0] sub_op1;
    logic [WIDTH-1:0] sub_op2;
    logic [WIDTH-1:0] sub_result;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_negative;
    logic             out_overflow;

    // Issue-stage view.
    modport slave (
        input  in_valid, in_op1, in_op2, sub_result, out_ready,
        output in_ready, sub_enable, sub_op1, sub_op2,
               out_valid, out_result, out_zero, out_negative, out_overflow
    );

    // Surrounding pipeline view (register-read stage, subtracter, consumer).
    modport master (
        output in_valid, in_op1, in_op2, sub_result, out_ready,
        input  in_ready, sub_enable, sub_op1, sub_op2,
               out_valid, out_result, out_zero, out_negative, out_overflow
    );

endinterface

// File: rtl/sub_operand_fifo.sv
// Operand-pair FIFO: stores {op1, op2}, head visible on dout while non-empty.
module sub_operand_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [2*WIDTH-1:0] din,
    output logic [2*WIDTH-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               wr_en;
    logic               rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/alu_sub_issue.sv
// Issue stage for the ALU subtracter: buffers operand pairs, pulses the
// subtracter once per pair and returns the difference with status flags.
module alu_sub_issue
    import alu_sub_issue_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset,
    alu_sub_issue_if.slave bus
);

    issue_state_t       state_q;
    logic               sub_enable_q;
    logic [WIDTH-1:0]   sub_op1_q;
    logic [WIDTH-1:0]   sub_op2_q;
    logic               s1_q;
    logic               s2_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_result_q;
    sub_flags_t         flags_q;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*WIDTH-1:0] fifo_dout;
    logic [WIDTH-1:0]   head_op1;
    logic [WIDTH-1:0]   head_op2;
    logic               out_free;
    logic               queued;
    logic               start_issue;
    sub_flags_t         cap_flags;

    sub_operand_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({bus.in_op1, bus.in_op2}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_push = bus.in_valid && !fifo_full;
    assign fifo_pop  = (state_q == ISSUE);
    assign out_free  = !out_valid_q || bus.out_ready;
    assign queued    = !fifo_empty || fifo_push;

    // A pair written while the FIFO is empty is forwarded straight from the input.
    assign {head_op1, head_op2} = fifo_empty ? {bus.in_op1, bus.in_op2} : fifo_dout;

    // Back-to-back issue from CAPTURE needs the consumer ready now, so the
    // freshly loaded result is likely gone before the next CAPTURE; CAPTURE
    // itself waits if it is not, so a result is never overwritten.
    assign start_issue = ((state_q == IDLE) && !fifo_empty && out_free) ||
                         ((state_q == CAPTURE) && queued && bus.out_ready);

    assign cap_flags = sub_flags(bus.sub_result == '0, bus.sub_result[WIDTH-1], s1_q, s2_q);

    // Issue FSM with registered subtracter controls, result register and flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sub_enable_q <= 1'b0;
            sub_op1_q    <= '0;
            sub_op2_q    <= '0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            flags_q      <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

            if (start_issue) begin
                sub_op1_q <= head_op1;
                sub_op2_q <= head_op2;
                s1_q      <= head_op1[WIDTH-1];
                s2_q      <= head_op2[WIDTH-1];
            end

            case (state_q)
                IDLE: begin
                    if (start_issue) begin
                        state_q      <= ISSUE;
                        sub_enable_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q      <= CAPTURE;
                    sub_enable_q <= 1'b0;
                end
                CAPTURE: begin
                    if (out_free) begin
                        out_valid_q  <= 1'b1;
                        out_result_q <= bus.sub_result;
                        flags_q      <= cap_flags;
                        if (start_issue) begin
                            state_q      <= ISSUE;
                            sub_enable_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    sub_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = !fifo_full;
    assign bus.sub_enable   = sub_enable_q;
    assign bus.sub_op1      = sub_op1_q;
    assign bus.sub_op2      = sub_op2_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_result   = out_result_q;
    assign bus.out_zero     = flags_q.zero;
    assign bus.out_negative = flags_q.negative;
    assign bus.out_overflow = flags_q.overflow;

endmodule

// File: tb/tb_alu_sub_issue.sv
// Directed and scoreboarded checks of the subtracter issue stage.
module tb_alu_sub_issue;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;

    localparam logic [15:0] BP_A [6] = '{16'd100, 16'hFFFB, 16'h0000, 16'd1000, 16'h8000, 16'h1234};
    localparam logic [15:0] BP_B [6] = '{16'd1,   16'd10,   16'h0000, 16'hFC18, 16'h8000, 16'h0234};
    localparam logic [15:0] BP_R [6] = '{16'h0063, 16'hFFF1, 16'h0000, 16'h07D0, 16'h0000, 16'h1000};

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        n;
        logic        o;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   issue_cnt = 0;

    alu_sub_issue_if #(.WIDTH(WIDTH)) bus ();

    alu_sub_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Behavioural subtracter: registers the difference on the edge ending ISSUE.
    always_ff @(posedge clock) begin
        if (bus.sub_enable) bus.sub_result <= bus.sub_op1 - bus.sub_op2;
    end

    // Count issue pulses.
    always @(posedge clock) begin
        if (bus.sub_enable) issue_cnt <= issue_cnt + 1;
    end

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.res = a - b;
        e.z   = (e.res == 16'h0000);
        e.n   = e.res[15];
        e.o   = (a[15] != b[15]) && (e.res[15] != a[15]);
        return e;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_one(input logic [15:0] a, input logic [15:0] b, output bit seen);
        bus.in_valid = 1'b1;
        bus.in_op1   = a;
        bus.in_op2   = b;
        step();
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
        checks++; if (bus.sub_enable !== 1'b0) begin errors++; $display("FAIL reset_sub_enable: got %0b expected 0", bus.sub_enable); end
        checks++; if (bus.sub_op1 !== 16'h0 || bus.sub_op2 !== 16'h0) begin errors++; $display("FAIL reset_sub_ops: got %h/%h expected 0/0", bus.sub_op1, bus.sub_op2); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
        checks++; if ({bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow} !== 19'h0) begin
            errors++; $display("FAIL reset_result_flags: got %h %b%b%b expected 0 000", bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow);
        end
        reset = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.sub_enable !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got valid=%0b en=%0b expected 0/0", bus.out_valid, bus.sub_enable); end
    endtask

    task automatic test_single_op();
        int base;
        base = issue_cnt;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_op1    = 16'd5;
        bus.in_op2    = 16'd3;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid_c1: got %0b expected 0", bus.out_valid); end
        step();
        checks++; if (bus.sub_enable !== 1'b1) begin errors++; $display("FAIL single_issue_enable: got %0b expected 1", bus.sub_enable); end
        checks++; if (bus.sub_op1 !== 16'd5 || bus.sub_op2 !== 16'd3) begin errors++; $display("FAIL single_issue_ops: got %0d/%0d expected 5/3", bus.sub_op1, bus.sub_op2); end
        step();
        checks++; if (bus.sub_enable !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_capture: got en=%0b valid=%0b expected 0/0", bus.sub_enable, bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got valid=%0b expected 1", bus.out_valid); end
        checks++; if ({bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow} !== {16'd2, 3'b000}) begin
            errors++; $display("FAIL single_result: got %h %b%b%b expected 0002 000", bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow);
        end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %0b expected 0", bus.out_valid); end
        step();
        step();
        checks++; if (issue_cnt - base != 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", issue_cnt - base); end
        checks++; if (bus.sub_op1 !== 16'd5 || bus.sub_op2 !== 16'd3) begin errors++; $display("FAIL single_ops_hold: got %0d/%0d expected 5/3", bus.sub_op1, bus.sub_op2); end
    endtask

    task automatic test_overflow();
        bit seen;
        bus.out_ready = 1'b1;
        issue_one(16'h8000, 16'h0001, seen);
        checks++; if (!seen) begin errors++; $display("FAIL ovf1_timeout: got no out_valid expected one within 20 cycles"); end
        checks++; if ({bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow} !== {16'h7FFF, 3'b001}) begin
            errors++; $display("FAIL ovf1_result: got %h %b%b%b expected 7fff 001", bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow);
        end
        step();
        issue_one(16'h7FFF, 16'hFFFF, seen);
        checks++; if (!seen) begin errors++; $display("FAIL ovf2_timeout: got no out_valid expected one within 20 cycles"); end
        checks++; if ({bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow} !== {16'h8000, 3'b011}) begin
            errors++; $display("FAIL ovf2_result: got %h %b%b%b expected 8000 011", bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow);
        end
        step();
    endtask

    task automatic test_zero_negative();
        bit seen;
        bus.out_ready = 1'b1;
        issue_one(16'd7, 16'd7, seen);
        checks++; if (!seen) begin errors++; $display("FAIL zero_timeout: got no out_valid expected one within 20 cycles"); end
        checks++; if ({bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow} !== {16'h0000, 3'b100}) begin
            errors++; $display("FAIL zero_result: got %h %b%b%b expected 0000 100", bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow);
        end
        step();
        issue_one(16'd2, 16'd9, seen);
        checks++; if (!seen) begin errors++; $display("FAIL neg_timeout: got no out_valid expected one within 20 cycles"); end
        checks++; if ({bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow} !== {16'hFFF9, 3'b010}) begin
            errors++; $display("FAIL neg_result: got %h %b%b%b expected fff9 010", bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int  base;
        int  accepted;
        int  idx;
        int  got;
        bit  acc_now;
        base          = issue_cnt;
        accepted      = 0;
        idx           = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op1    = BP_A[0];
        bus.in_op2    = BP_B[0];
        for (int cyc = 0; cyc < 12; cyc++) begin
            acc_now = bus.in_valid && bus.in_ready;
            step();
            if (acc_now) begin
                accepted++;
                idx++;
                if (idx < 6) begin
                    bus.in_op1 = BP_A[idx];
                    bus.in_op2 = BP_B[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        checks++; if (accepted != DEPTH + 1) begin errors++; $display("FAIL bp_accepted: got %0d expected %0d", accepted, DEPTH + 1); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b expected 0", bus.in_ready); end
        checks++; if (issue_cnt - base != 1) begin errors++; $display("FAIL bp_issue_count: got %0d expected 1", issue_cnt - base); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== BP_R[0]) begin
            errors++; $display("FAIL bp_parked: got valid=%0b result=%h expected 1/%h", bus.out_valid, bus.out_result, BP_R[0]);
        end
        bus.out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            acc_now = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                checks++; if (bus.out_result !== BP_R[got]) begin errors++; $display("FAIL bp_drain_%0d: got %h expected %h", got, bus.out_result, BP_R[got]); end
                got++;
            end
            step();
            if (acc_now) begin
                idx++;
                if (idx < 6) begin
                    bus.in_op1 = BP_A[idx];
                    bus.in_op2 = BP_B[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (got != 6) begin errors++; $display("FAIL bp_drain_count: got %0d expected 6", got); end
        step();
    endtask

    task automatic test_reset_mid_op();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op1    = 16'd10;
        bus.in_op2    = 16'd4;
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'd6) begin
            errors++; $display("FAIL rst_parked: got valid=%0b result=%h expected 1/0006", bus.out_valid, bus.out_result);
        end
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op1   = 16'(i + 1);
            bus.in_op2   = 16'h0000;
            step();
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_fifo_full: got in_ready=%0b expected 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.sub_enable !== 1'b1) begin errors++; $display("FAIL rst_issue: got en=%0b expected 1", bus.sub_enable); end
        step();
        reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.sub_enable !== 1'b0) begin
            errors++; $display("FAIL rst_async_ctrl: got in_ready=%0b en=%0b expected 1/0", bus.in_ready, bus.sub_enable);
        end
        checks++; if (bus.sub_op1 !== 16'h0 || bus.sub_op2 !== 16'h0) begin errors++; $display("FAIL rst_async_ops: got %h/%h expected 0/0", bus.sub_op1, bus.sub_op2); end
        checks++; if ({bus.out_valid, bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow} !== 20'h0) begin
            errors++; $display("FAIL rst_async_out: got valid=%0b %h %b%b%b expected 0 0000 000", bus.out_valid, bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (bus.out_valid !== 1'b0 || bus.sub_enable !== 1'b0) begin
                errors++; $display("FAIL rst_quiet_%0d: got valid=%0b en=%0b expected 0/0", i, bus.out_valid, bus.sub_enable);
            end
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int   sent;
        int   rcvd;
        bit   push_now;
        bit   pop_now;
        sent         = 0;
        rcvd         = 0;
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 20000 && rcvd < 500; cyc++) begin
            if (!bus.in_valid && sent < 500 && $urandom_range(0, 3) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_op1   = 16'($urandom);
                bus.in_op2   = 16'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            push_now = bus.in_valid && bus.in_ready;
            pop_now  = bus.out_valid && bus.out_ready;
            if (push_now) begin
                q.push_back(model(bus.in_op1, bus.in_op2));
                sent++;
            end
            if (pop_now) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected_%0d: got result %h expected no output", rcvd, bus.out_result);
                end else begin
                    e = q.pop_front();
                    if ({bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow} !== e) begin
                        errors++; $display("FAIL rand_item_%0d: got %h %b%b%b expected %h %b%b%b", rcvd, bus.out_result,
                                           bus.out_zero, bus.out_negative, bus.out_overflow, e.res, e.z, e.n, e.o);
                    end
                end
                rcvd++;
            end
            step();
            if (push_now) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        checks++; if (rcvd != 500) begin errors++; $display("FAIL rand_count: got %0d results expected 500", rcvd); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op1    = '0;
        bus.in_op2    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_op();
        test_overflow();
        test_zero_negative();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running expected completion before 5 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
